soc_sram_responder: RTL and testbench

SOC_SRAM_RESPONDER -- requirements
Module: soc_sram_responder

---
 rtl/soc_sram_responder.sv | 149 ++++++++++++++
 tb/tb_soc_sram_responder.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/soc_sram_responder.sv
// SoC SRAM responder: dual-port word RAM (instruction read, data read/write)
// plus a small memory-mapped config block (timer, LEDs, switches, 7-seg value).

module soc_sram_lane #(
  parameter int AW    = 10,
  parameter int VEC_W = 8
) (
  input  logic             clk,
  input  logic             d_we,
  input  logic [AW-1:0]    d_addr,
  input  logic [VEC_W-1:0] d_wdata,
  input  logic [AW-1:0]    i_addr,
  output logic [VEC_W-1:0] d_q,
  output logic [VEC_W-1:0] i_q
);
  localparam int DEPTH = 1 << AW;

  // Contents are deliberately unreset so they survive a reset pulse.
  logic [VEC_W-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (d_we) mem[d_addr] <= d_wdata;
  end

  // Combinational taps; the parent registers them, which yields read-first.
  assign d_q = mem[d_addr];
  assign i_q = mem[i_addr];
endmodule

module soc_sram_responder #(
  parameter int AW = 10
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [15:0] switch,
  output logic [15:0] led,
  output logic [31:0] num
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  localparam logic [15:0] CFG_BASE   = 16'h1faf;
  localparam logic [15:0] OFF_TIMER  = 16'he000;
  localparam logic [15:0] OFF_LED    = 16'hf000;
  localparam logic [15:0] OFF_SWITCH = 16'hf010;
  localparam logic [15:0] OFF_NUM    = 16'hf020;

  logic                              cfg_sel;
  logic                              ram_wr;
  logic                              cfg_wr;
  logic [15:0]                       cfg_off;
  logic [AW-1:0]                     d_word;
  logic [AW-1:0]                     i_word;
  logic [NUM_LANES-1:0][VEC_W-1:0]   ram_d;
  logic [NUM_LANES-1:0][VEC_W-1:0]   ram_i;
  logic [31:0]                       timer;
  logic [31:0]                       timer_inc;
  logic [31:0]                       timer_nxt;
  logic [15:0]                       led_q;
  logic [31:0]                       num_q;
  logic [31:0]                       cfg_rd;
  logic                              unused_bits;

  assign cfg_sel = (data_sram_addr[31:16] == CFG_BASE);
  assign cfg_off = data_sram_addr[15:0];
  assign ram_wr  = data_sram_en && !cfg_sel && (data_sram_wen != 4'b0);
  assign cfg_wr  = data_sram_en &&  cfg_sel && (data_sram_wen != 4'b0);
  assign d_word  = data_sram_addr[AW+1:2];
  assign i_word  = inst_sram_addr[AW+1:2];

  assign unused_bits = ^{inst_sram_wen, inst_sram_wdata,
                         inst_sram_addr[31:AW+2], inst_sram_addr[1:0],
                         data_sram_addr[1:0]};

  // One byte-wide RAM slice per write-enable lane.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    soc_sram_lane #(.AW(AW), .VEC_W(VEC_W)) u_lane (
      .clk     (clk),
      .d_we    (ram_wr && data_sram_wen[g]),
      .d_addr  (d_word),
      .d_wdata (data_sram_wdata[VEC_W*g +: VEC_W]),
      .i_addr  (i_word),
      .d_q     (ram_d[g]),
      .i_q     (ram_i[g])
    );
  end

  // Written bytes override the free-running increment in the same cycle.
  assign timer_inc = timer + 32'd1;
  always_comb begin
    timer_nxt = timer_inc;
    for (int b = 0; b < NUM_LANES; b++) begin
      if (cfg_wr && cfg_off == OFF_TIMER && data_sram_wen[b])
        timer_nxt[VEC_W*b +: VEC_W] = data_sram_wdata[VEC_W*b +: VEC_W];
    end
  end

  always_comb begin
    cfg_rd = 32'h0;
    case (cfg_off)
      OFF_TIMER:  cfg_rd = timer;
      OFF_LED:    cfg_rd = {16'h0, led_q};
      OFF_SWITCH: cfg_rd = {16'h0, switch};
      OFF_NUM:    cfg_rd = num_q;
      default:    cfg_rd = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer <= 32'h0;
      led_q <= 16'h0;
      num_q <= 32'h0;
    end else begin
      timer <= timer_nxt;
      if (cfg_wr && cfg_off == OFF_LED) begin
        if (data_sram_wen[0]) led_q[7:0]  <= data_sram_wdata[7:0];
        if (data_sram_wen[1]) led_q[15:8] <= data_sram_wdata[15:8];
      end
      if (cfg_wr && cfg_off == OFF_NUM) begin
        for (int b = 0; b < NUM_LANES; b++)
          if (data_sram_wen[b]) num_q[VEC_W*b +: VEC_W] <= data_sram_wdata[VEC_W*b +: VEC_W];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_sram_rdata <= 32'h0;
      data_sram_rdata <= 32'h0;
    end else begin
      if (inst_sram_en) inst_sram_rdata <= ram_i;
      if (data_sram_en) data_sram_rdata <= cfg_sel ? cfg_rd : ram_d;
    end
  end

  assign led = led_q;
  assign num = num_q;
endmodule

// File: tb/tb_soc_sram_responder.sv
// Directed bench for soc_sram_responder: RAM byte writes, read-first, cross-port
// collision, config registers, timer wrap/merge and asynchronous reset.

module tb_soc_sram_responder;
  logic        clk;
  logic        resetn;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [15:0] switch;
  logic [15:0] led;
  logic [31:0] num;

  int compared   = 0;
  int mismatched = 0;

  soc_sram_responder #(.AW(10)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .switch          (switch),
    .led             (led),
    .num             (num)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dacc(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    data_sram_en    = 1'b1;
    data_sram_addr  = a;
    data_sram_wen   = w;
    data_sram_wdata = d;
  endtask

  initial begin
    resetn = 1'b0;
    inst_sram_en = 1'b0; inst_sram_wen = 4'h0; inst_sram_addr = 32'h0; inst_sram_wdata = 32'h0;
    data_sram_en = 1'b0; data_sram_wen = 4'h0; data_sram_addr = 32'h0; data_sram_wdata = 32'h0;
    switch = 16'h00F0;

    #2;
    chk("rst_inst_rdata", inst_sram_rdata, 32'h0);
    chk("rst_data_rdata", data_sram_rdata, 32'h0);
    chk("rst_led", {16'h0, led}, 32'h0);
    chk("rst_num", num, 32'h0);

    // Release reset with a request already posted for the first edge.
    @(negedge clk);
    resetn = 1'b1;
    dacc(32'h10, 4'b1111, 32'h11223344); step();
    dacc(32'h10, 4'b0010, 32'hAABBCCDD); step();
    chk("read_first", data_sram_rdata, 32'h11223344);
    dacc(32'h10, 4'b0000, 32'h0); step();
    chk("byte_write", data_sram_rdata, 32'h1122CC44);

    dacc(32'h20, 4'b1111, 32'hCAFEF00D); step();
    dacc(32'h20, 4'b1111, 32'h11223344);
    inst_sram_en = 1'b1; inst_sram_addr = 32'h20; step();
    chk("collision_old", inst_sram_rdata, 32'hCAFEF00D);
    data_sram_en = 1'b0; step();
    chk("cross_port_new", inst_sram_rdata, 32'h11223344);
    inst_sram_addr = 32'h12; step();
    chk("inst_low_bits", inst_sram_rdata, 32'h1122CC44);
    inst_sram_addr = 32'h1faf0010; step();
    chk("inst_no_decode", inst_sram_rdata, 32'h1122CC44);
    inst_sram_en = 1'b0;

    dacc(32'h1faf0010, 4'b1111, 32'hDEADBEEF); step();
    dacc(32'h13, 4'b0000, 32'h0); step();
    chk("cfg_no_ram", data_sram_rdata, 32'h1122CC44);

    dacc(32'h1faff000, 4'b1111, 32'h0000A5A5); step();
    chk("led_out", {16'h0, led}, 32'h0000A5A5);
    dacc(32'h1faff000, 4'b0000, 32'h0); step();
    chk("led_read", data_sram_rdata, 32'h0000A5A5);
    dacc(32'h1faff010, 4'b1111, 32'hFFFFFFFF); step();
    dacc(32'h1faff010, 4'b0000, 32'h0); step();
    chk("switch_read", data_sram_rdata, 32'h000000F0);
    dacc(32'h1faff020, 4'b0101, 32'h12345678); step();
    chk("num_bytes", num, 32'h00340078);
    dacc(32'h1faff000, 4'b1111, 32'hFFFF1234); step();
    chk("led_low16", {16'h0, led}, 32'h00001234);
    dacc(32'h1faff000, 4'b0000, 32'h0); step();
    chk("led_upper_zero", data_sram_rdata, 32'h00001234);

    // Timer: fffffffe -> ffffffff -> 0 across two idle edges.
    dacc(32'h1fafe000, 4'b1111, 32'hFFFFFFFE); step();
    data_sram_en = 1'b0; step(); step();
    dacc(32'h1fafe000, 4'b0000, 32'h0); step();
    chk("timer_wrap", data_sram_rdata, 32'h00000000);
    step();
    chk("timer_incr", data_sram_rdata, 32'h00000001);
    dacc(32'h1fafe000, 4'b0001, 32'h000000AA); step();
    dacc(32'h1fafe000, 4'b0000, 32'h0); step();
    chk("timer_merge", data_sram_rdata, 32'h000000AA);
    data_sram_en = 1'b0; step();
    chk("rdata_hold", data_sram_rdata, 32'h000000AA);
    dacc(32'h1faf0004, 4'b0000, 32'h0); step();
    chk("unmapped_zero", data_sram_rdata, 32'h0);

    inst_sram_en = 1'b1; inst_sram_addr = 32'h10;
    dacc(32'h10, 4'b0000, 32'h0); step();
    chk("pre_rst_read", data_sram_rdata, 32'h1122CC44);
    inst_sram_en = 1'b0; data_sram_en = 1'b0;

    // Asynchronous reset between edges.
    #2 resetn = 1'b0;
    #1;
    chk("async_data", data_sram_rdata, 32'h0);
    chk("async_inst", inst_sram_rdata, 32'h0);
    chk("async_led", {16'h0, led}, 32'h0);
    chk("async_num", num, 32'h0);
    step();
    chk("held_in_rst", data_sram_rdata, 32'h0);

    @(negedge clk);
    resetn = 1'b1;
    dacc(32'h1fafe000, 4'b0000, 32'h0); step();
    chk("timer_after_rst", data_sram_rdata, 32'h0);
    dacc(32'h10, 4'b0000, 32'h0); step();
    chk("ram_kept", data_sram_rdata, 32'h1122CC44);
    dacc(32'h1fafe000, 4'b0000, 32'h0); step();
    chk("timer_restart", data_sram_rdata, 32'h00000002);
    data_sram_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
